// File: rtl/idli_pkg.sv
// Shared types for the idli decode front end: micro-op bundle, field enums,
// decode-buffer FSM states and default stream geometry.
package idli_pkg;

    localparam int unsigned DE_DATA_W = 16;
    localparam int unsigned DE_NIB_W  = 4;
    localparam int unsigned DE_BEATS  = DE_DATA_W / DE_NIB_W;

    typedef logic [15:0] data_t;
    typedef logic [3:0]  reg_t;

    typedef enum logic [2:0] {
        PIPE_ALU    = 3'd0,
        PIPE_SHIFT  = 3'd1,
        PIPE_MEM    = 3'd2,
        PIPE_BRANCH = 3'd3,
        PIPE_SYS    = 3'd4
    } pipe_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'd0,
        ALU_OP_AND = 2'd1,
        ALU_OP_OR  = 2'd2,
        ALU_OP_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        CMP_OP_NONE = 2'd0,
        CMP_OP_EQ   = 2'd1,
        CMP_OP_LT   = 2'd2,
        CMP_OP_LTU  = 2'd3
    } cmp_op_t;

    typedef enum logic [1:0] {
        SHIFT_OP_NONE = 2'd0,
        SHIFT_OP_SHL  = 2'd1,
        SHIFT_OP_SHR  = 2'd2,
        SHIFT_OP_SAR  = 2'd3
    } shift_op_t;

    typedef enum logic [2:0] {
        DST_NULL = 3'd0,
        DST_REG  = 3'd1,
        DST_FLAG = 3'd2,
        DST_PC   = 3'd3,
        DST_MEM  = 3'd4
    } dst_t;

    typedef enum logic [1:0] {
        SRC_REG  = 2'd0,
        SRC_SQI  = 2'd1,
        SRC_ZERO = 2'd2,
        SRC_PC   = 2'd3
    } src_t;

    typedef enum logic [2:0] {
        AUX_NONE = 3'd0,
        AUX_LD   = 3'd1,
        AUX_ST   = 3'd2,
        AUX_NOP  = 3'd3,
        AUX_HALT = 3'd4
    } aux_t;

    typedef struct packed {
        pipe_t     pipe;
        alu_op_t   alu_op;
        logic      alu_inv;
        logic      alu_cin;
        cmp_op_t   cmp_op;
        shift_op_t shift_op;
        dst_t      dst;
        reg_t      dst_reg;
        src_t      lhs;
        reg_t      lhs_reg;
        src_t      rhs;
        reg_t      rhs_reg;
        aux_t      aux;
    } uop_t;

    typedef enum logic {
        DE_INSN = 1'b0,
        DE_IMM  = 1'b1
    } de_state_t;

    // An instruction whose right operand streams in as the following word.
    function automatic logic uop_needs_imm(uop_t u);
        return u.rhs == SRC_SQI;
    endfunction

endpackage

// File: rtl/idli_decode_buf_if.sv
// Nibble-stream input and decoded-queue output bundle of the decode buffer.
interface idli_decode_buf_if
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NIB_W  = 4,
    parameter int unsigned DATA_W = 16
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [NIB_W-1:0]  i_de_nib;
    logic              i_de_nib_vld;
    logic              o_de_ready;
    logic              i_de_flush;
    logic              o_de_vld;
    uop_t              o_de_uop;
    logic [DATA_W-1:0] o_de_imm;
    logic              i_de_ack;
    logic [CNT_W-1:0]  o_de_cnt;
    logic              o_de_wait_imm;

    // Upstream/consumer side: feeds nibbles, flushes and acknowledges.
    modport master (
        output i_de_nib, i_de_nib_vld, i_de_flush, i_de_ack,
        input  o_de_ready, o_de_vld, o_de_uop, o_de_imm, o_de_cnt, o_de_wait_imm
    );

    // Decode buffer side.
    modport slave (
        input  i_de_nib, i_de_nib_vld, i_de_flush, i_de_ack,
        output o_de_ready, o_de_vld, o_de_uop, o_de_imm, o_de_cnt, o_de_wait_imm
    );

endinterface

// File: rtl/idli_decode_table_m.sv
// Combinational instruction decode: 16-bit encoding {C, B, A, op} to micro-op.
// C == 4'hF selects a streamed immediate except in the unary and system forms,
// where C is a sub-opcode instead.
module idli_decode_table_m
    import idli_pkg::*;
(
    input  data_t i_enc,
    output uop_t  o_uop
);

    reg_t a;
    reg_t b;
    reg_t c;

    assign a = i_enc[7:4];
    assign b = i_enc[11:8];
    assign c = i_enc[15:12];

    // Shared register-form defaults, then per-opcode overrides.
    always_comb begin
        o_uop         = '0;
        o_uop.pipe    = PIPE_ALU;
        o_uop.alu_op  = ALU_OP_ADD;
        o_uop.dst     = DST_REG;
        o_uop.dst_reg = a;
        o_uop.lhs     = SRC_REG;
        o_uop.lhs_reg = b;
        o_uop.rhs     = (c == 4'hF) ? SRC_SQI : SRC_REG;
        o_uop.rhs_reg = c;

        casez (i_enc)
            16'b????_????_????_0000: ;
            16'b????_????_????_0001: begin
                o_uop.alu_inv = 1'b1;
                o_uop.alu_cin = 1'b1;
            end
            16'b????_????_????_0010: o_uop.alu_op = ALU_OP_AND;
            16'b????_????_????_0011: o_uop.alu_op = ALU_OP_OR;
            16'b????_????_????_0100: o_uop.alu_op = ALU_OP_XOR;
            16'b????_????_????_01??: begin
                // 0101..0111: compare A-flag <- B ? C via subtract
                o_uop.alu_inv = 1'b1;
                o_uop.alu_cin = 1'b1;
                o_uop.dst     = DST_FLAG;
                casez (i_enc[1:0])
                    2'b01:   o_uop.cmp_op = CMP_OP_EQ;
                    2'b10:   o_uop.cmp_op = CMP_OP_LT;
                    default: o_uop.cmp_op = CMP_OP_LTU;
                endcase
            end
            16'b????_????_????_10??: begin
                if (i_enc[1:0] == 2'b11) begin
                    // 1011: load A <- mem[B + C]
                    o_uop.pipe = PIPE_MEM;
                    o_uop.aux  = AUX_LD;
                end else begin
                    o_uop.pipe = PIPE_SHIFT;
                    casez (i_enc[1:0])
                        2'b00:   o_uop.shift_op = SHIFT_OP_SHL;
                        2'b01:   o_uop.shift_op = SHIFT_OP_SHR;
                        default: o_uop.shift_op = SHIFT_OP_SAR;
                    endcase
                end
            end
            16'b????_????_????_1100: begin
                o_uop.pipe = PIPE_MEM;
                o_uop.dst  = DST_MEM;
                o_uop.aux  = AUX_ST;
            end
            16'b????_????_????_1101: begin
                o_uop.pipe = PIPE_BRANCH;
                o_uop.dst  = DST_PC;
                o_uop.lhs  = SRC_PC;
            end
            16'b????_????_????_1110: begin
                // Unary forms: C is a sub-opcode, never an immediate marker.
                o_uop.rhs = SRC_ZERO;
                casez (c)
                    4'b0001: begin
                        o_uop.alu_op  = ALU_OP_XOR;
                        o_uop.alu_inv = 1'b1;
                    end
                    4'b0010: begin
                        o_uop.lhs     = SRC_ZERO;
                        o_uop.rhs     = SRC_REG;
                        o_uop.rhs_reg = b;
                        o_uop.alu_inv = 1'b1;
                        o_uop.alu_cin = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: begin
                // System forms: C is a sub-opcode, never an immediate marker.
                o_uop.pipe = PIPE_SYS;
                o_uop.dst  = DST_NULL;
                o_uop.lhs  = SRC_ZERO;
                o_uop.rhs  = SRC_ZERO;
                o_uop.aux  = (c == 4'hF) ? AUX_HALT : AUX_NOP;
            end
        endcase
    end

endmodule

// File: rtl/idli_decode_buf_m.sv
// Decode buffer: assembles words from the nibble stream, decodes them, merges
// a trailing immediate into the same entry and queues entries for execute.
module idli_decode_buf_m
    import idli_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NIB_W  = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic             i_de_gck,
    input  logic             i_de_rst_n,
    idli_decode_buf_if.slave de_if
);

    localparam int unsigned BEATS  = DATA_W / NIB_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef struct packed {
        uop_t              uop;
        logic [DATA_W-1:0] imm;
    } entry_t;

    de_state_t         state_q,  state_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic [DATA_W-1:0] word_q,   word_d;
    uop_t              stage_q,  stage_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];

    logic              flush;
    logic              ready;
    logic              vld;
    logic              accept;
    logic              word_done;
    logic              push;
    logic              pop;
    int unsigned       nib_lsb;
    logic [DATA_W-1:0] asm_word;
    uop_t              dec_uop;
    entry_t            push_entry;
    entry_t            head;

    assign flush     = de_if.i_de_flush;
    assign ready     = cnt_q < FULL_CNT;
    assign vld       = cnt_q != '0;
    assign accept    = de_if.i_de_nib_vld && ready && !flush;
    assign word_done = accept && (beat_q == LAST_BEAT);
    assign pop       = de_if.i_de_ack && vld && !flush;
    assign nib_lsb   = 32'(beat_q) * NIB_W;

    // Word as it stands including this cycle's nibble; decoded on the last beat.
    always_comb begin
        asm_word                    = word_q;
        asm_word[nib_lsb +: NIB_W]  = de_if.i_de_nib;
    end

    idli_decode_table_m u_table (
        .i_enc (data_t'(asm_word)),
        .o_uop (dec_uop)
    );

    // Instruction/immediate sequencing; an immediate-carrying instruction is
    // held in the staging register and pushed together with its immediate.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        push       = 1'b0;
        push_entry = '0;
        if (word_done) begin
            if (state_q == DE_INSN) begin
                if (uop_needs_imm(dec_uop)) begin
                    stage_d = dec_uop;
                    state_d = DE_IMM;
                end else begin
                    push           = 1'b1;
                    push_entry.uop = dec_uop;
                end
            end else begin
                push           = 1'b1;
                push_entry.uop = stage_q;
                push_entry.imm = asm_word;
                state_d        = DE_INSN;
            end
        end
        if (flush) begin
            state_d = DE_INSN;
            stage_d = '0;
        end
    end

    // Beat counter and partial-word register.
    always_comb begin
        beat_d = beat_q;
        word_d = word_q;
        if (accept) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
            word_d = asm_word;
        end
        if (flush) begin
            beat_d = '0;
            word_d = '0;
        end
    end

    // Queue pointers and occupancy.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: ;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Queue storage write.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
        end
    end

    // Control state: FSM, assembler, staging register and queue pointers.
    always_ff @(posedge i_de_gck or negedge i_de_rst_n) begin
        if (!i_de_rst_n) begin
            state_q  <= DE_INSN;
            beat_q   <= '0;
            word_q   <= '0;
            stage_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            word_q   <= word_d;
            stage_q  <= stage_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only observed while counted as occupied.
    always_ff @(posedge i_de_gck) begin
        mem_q <= mem_d;
    end

    assign head                = mem_q[rd_ptr_q];
    assign de_if.o_de_ready    = ready;
    assign de_if.o_de_vld      = vld;
    assign de_if.o_de_uop      = vld ? head.uop : '0;
    assign de_if.o_de_imm      = vld ? head.imm : '0;
    assign de_if.o_de_cnt      = cnt_q;
    assign de_if.o_de_wait_imm = (state_q == DE_IMM);

endmodule
